// File: rtl/wb16_to_sdram_bridge.sv
// rtl/wb16_to_sdram_bridge.sv - 16-bit classic Wishbone slave to single 32-bit LiteX Wishbone master access
// Halfword accesses are steered onto one byte-lane pair of the main-RAM word; errors and timeouts are counted.
module wb16_to_sdram_bridge #(
    parameter int          ADDR_WIDTH     = 16,
    parameter logic [29:0] BASE_WORD_ADR  = 30'h1000_0000,
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [15:0] ERR_DATA       = 16'hDEAD
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] s_adr,
    input  logic [15:0]           s_dat_w,
    output logic [15:0]           s_dat_r,
    input  logic                  s_we,
    input  logic                  s_cyc,
    input  logic                  s_stb,
    output logic                  s_ack,
    output logic [29:0]           m_adr,
    output logic [31:0]           m_dat_w,
    input  logic [31:0]           m_dat_r,
    output logic [3:0]            m_sel,
    output logic                  m_we,
    output logic                  m_cyc,
    output logic                  m_stb,
    input  logic                  m_ack,
    input  logic                  m_err,
    output logic [2:0]            m_cti,
    output logic [1:0]            m_bte,
    input  logic                  clr_status,
    output logic                  timeout_flag,
    output logic [7:0]            err_count
);

    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP,
        RELEASE
    } state_t;

    state_t               state_q, state_d;
    logic [29:0]          m_adr_q, m_adr_d;
    logic [31:0]          m_dat_w_q, m_dat_w_d;
    logic [3:0]           m_sel_q, m_sel_d;
    logic                 m_we_q, m_we_d;
    logic                 m_cyc_q, m_cyc_d;
    logic                 lane_q, lane_d;
    logic                 aborted_q, aborted_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [15:0]          s_dat_r_q, s_dat_r_d;
    logic                 s_ack_q, s_ack_d;
    logic                 timeout_flag_q, timeout_flag_d;
    logic [7:0]           err_count_q, err_count_d;
    logic                 err_evt;
    logic                 to_evt;
    logic                 done;

    always_comb begin
        state_d        = state_q;
        m_adr_d        = m_adr_q;
        m_dat_w_d      = m_dat_w_q;
        m_sel_d        = m_sel_q;
        m_we_d         = m_we_q;
        m_cyc_d        = m_cyc_q;
        lane_d         = lane_q;
        aborted_d      = aborted_q;
        timer_d        = timer_q;
        s_dat_r_d      = s_dat_r_q;
        s_ack_d        = 1'b0;
        timeout_flag_d = timeout_flag_q;
        err_count_d    = err_count_q;
        err_evt        = 1'b0;
        to_evt         = 1'b0;
        done           = 1'b0;

        case (state_q)
            IDLE: begin
                if (s_cyc && s_stb) begin
                    m_adr_d   = BASE_WORD_ADR + 30'(s_adr[ADDR_WIDTH-1:1]);
                    m_sel_d   = s_adr[0] ? 4'b1100 : 4'b0011;
                    m_dat_w_d = {s_dat_w, s_dat_w};
                    m_we_d    = s_we;
                    lane_d    = s_adr[0];
                    aborted_d = 1'b0;
                    state_d   = REQ;
                end
            end
            REQ: begin
                if (!s_cyc) begin
                    aborted_d = 1'b1;
                end
                // First REQ cycle only launches the master strobe; responses count from the next one.
                if (!m_cyc_q) begin
                    m_cyc_d = 1'b1;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                    if (m_err) begin
                        err_evt = 1'b1;
                        done    = 1'b1;
                        if (!m_we_q) s_dat_r_d = ERR_DATA;
                    end else if (m_ack) begin
                        done = 1'b1;
                        if (!m_we_q) s_dat_r_d = lane_q ? m_dat_r[31:16] : m_dat_r[15:0];
                    end else if (timer_q == TIMER_LAST) begin
                        err_evt = 1'b1;
                        to_evt  = 1'b1;
                        done    = 1'b1;
                        if (!m_we_q) s_dat_r_d = ERR_DATA;
                    end
                end
                if (done) begin
                    m_cyc_d = 1'b0;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (aborted_q) begin
                    state_d = IDLE;
                end else begin
                    s_ack_d = 1'b1;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (!s_stb) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (clr_status) begin
            timeout_flag_d = 1'b0;
            err_count_d    = 8'h00;
        end else begin
            if (to_evt) timeout_flag_d = 1'b1;
            if (err_evt && err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            m_adr_q        <= '0;
            m_dat_w_q      <= '0;
            m_sel_q        <= '0;
            m_we_q         <= 1'b0;
            m_cyc_q        <= 1'b0;
            lane_q         <= 1'b0;
            aborted_q      <= 1'b0;
            timer_q        <= '0;
            s_dat_r_q      <= '0;
            s_ack_q        <= 1'b0;
            timeout_flag_q <= 1'b0;
            err_count_q    <= '0;
        end else begin
            state_q        <= state_d;
            m_adr_q        <= m_adr_d;
            m_dat_w_q      <= m_dat_w_d;
            m_sel_q        <= m_sel_d;
            m_we_q         <= m_we_d;
            m_cyc_q        <= m_cyc_d;
            lane_q         <= lane_d;
            aborted_q      <= aborted_d;
            timer_q        <= timer_d;
            s_dat_r_q      <= s_dat_r_d;
            s_ack_q        <= s_ack_d;
            timeout_flag_q <= timeout_flag_d;
            err_count_q    <= err_count_d;
        end
    end

    assign s_dat_r      = s_dat_r_q;
    assign s_ack        = s_ack_q;
    assign m_adr        = m_adr_q;
    assign m_dat_w      = m_dat_w_q;
    assign m_sel        = m_sel_q;
    assign m_we         = m_we_q;
    assign m_cyc        = m_cyc_q;
    assign m_stb        = m_cyc_q;
    assign m_cti        = 3'b000;
    assign m_bte        = 2'b00;
    assign timeout_flag = timeout_flag_q;
    assign err_count    = err_count_q;

endmodule

// File: tb/tb_wb16_to_sdram_bridge.sv
// tb/tb_wb16_to_sdram_bridge.sv - self-checking bench for wb16_to_sdram_bridge
module tb_wb16_to_sdram_bridge;

    localparam int          TO   = 16;
    localparam logic [29:0] BASE = 30'h1000_0000;
    localparam logic [15:0] ERRD = 16'hDEAD;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] s_adr;
    logic [15:0] s_dat_w;
    logic [15:0] s_dat_r;
    logic        s_we;
    logic        s_cyc;
    logic        s_stb;
    logic        s_ack;
    logic [29:0] m_adr;
    logic [31:0] m_dat_w;
    logic [31:0] m_dat_r;
    logic [3:0]  m_sel;
    logic        m_we;
    logic        m_cyc;
    logic        m_stb;
    logic        m_ack;
    logic        m_err;
    logic [2:0]  m_cti;
    logic [1:0]  m_bte;
    logic        clr_status;
    logic        timeout_flag;
    logic [7:0]  err_count;

    int errors = 0;
    int checks = 0;

    logic [15:0] mdl_rdata;
    logic [7:0]  mdl_errc;
    logic        mdl_to;

    wb16_to_sdram_bridge #(
        .ADDR_WIDTH(16),
        .BASE_WORD_ADR(BASE),
        .TIMEOUT_CYCLES(TO),
        .ERR_DATA(ERRD)
    ) dut (
        .clk(clk), .reset(reset),
        .s_adr(s_adr), .s_dat_w(s_dat_w), .s_dat_r(s_dat_r), .s_we(s_we),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_ack(s_ack),
        .m_adr(m_adr), .m_dat_w(m_dat_w), .m_dat_r(m_dat_r), .m_sel(m_sel),
        .m_we(m_we), .m_cyc(m_cyc), .m_stb(m_stb), .m_ack(m_ack), .m_err(m_err),
        .m_cti(m_cti), .m_bte(m_bte),
        .clr_status(clr_status), .timeout_flag(timeout_flag), .err_count(err_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        we;
        logic [15:0] adr;
        logic [15:0] wd;
        logic [31:0] rd;
        int          lat;
        int          err_mode;
        int          hold;
        bit          abort;
        logic [29:0] e_adr;
        logic [3:0]  e_sel;
        logic [31:0] e_dw;
        logic [15:0] e_rdata;
        logic [7:0]  e_errc;
        logic        e_to;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic mdl_count_err();
        if (mdl_errc != 8'hFF) mdl_errc = mdl_errc + 8'd1;
    endtask

    // One slave access with a slave model that responds after lat strobe cycles
    // (lat >= TO means it never responds); err_mode 1 = m_err, 2 = m_err with m_ack.
    task automatic run_txn(input logic we, input logic [15:0] adr, input logic [15:0] wd,
                           input logic [31:0] rd, input int lat, input int err_mode,
                           input int hold, input bit abort, input bit clr_err,
                           output logic [29:0] c_adr, output logic [3:0] c_sel,
                           output logic [31:0] c_dw, output logic c_we);
        int stb_cycles, accesses, sacks, sack_iter, held, win, exp_stb;
        bit prev_stb, captured, released, timeout;
        logic [29:0] exp_adr;
        timeout    = (lat >= TO);
        exp_stb    = timeout ? TO : lat + 1;
        win        = exp_stb + 7 + hold;
        stb_cycles = 0; accesses = 0; sacks = 0; sack_iter = -1; held = 0;
        prev_stb   = 1'b0; captured = 1'b0; released = 1'b0;
        c_adr = '0; c_sel = '0; c_dw = '0; c_we = 1'b0;
        s_cyc = 1'b1; s_stb = 1'b1; s_we = we; s_adr = adr; s_dat_w = wd; m_dat_r = rd;
        for (int i = 0; i < win; i++) begin
            @(posedge clk); #1;
            m_ack = 1'b0; m_err = 1'b0; clr_status = 1'b0;
            if (m_stb) begin
                if (!prev_stb) accesses++;
                if (!captured) begin
                    captured = 1'b1;
                    c_adr = m_adr; c_sel = m_sel; c_dw = m_dat_w; c_we = m_we;
                end
                if (!timeout && stb_cycles == lat) begin
                    if (err_mode != 0) begin
                        m_err = 1'b1;
                        m_ack = (err_mode == 2);
                        clr_status = clr_err;
                    end else begin
                        m_ack = 1'b1;
                    end
                end
                stb_cycles++;
            end
            prev_stb = m_stb;
            if (s_ack) begin
                sacks++;
                if (sack_iter < 0) sack_iter = i;
            end
            if (abort && i == 1) begin
                s_cyc = 1'b0; s_stb = 1'b0;
            end
            if (sack_iter >= 0 && !released) begin
                if (held == hold) begin
                    s_cyc = 1'b0; s_stb = 1'b0; released = 1'b1;
                end else begin
                    held++;
                end
            end
        end
        m_ack = 1'b0; m_err = 1'b0; clr_status = 1'b0;
        s_cyc = 1'b0; s_stb = 1'b0;

        exp_adr = BASE + {15'b0, adr[15:1]};
        check("master accesses", accesses, 1);
        check("m_stb cycles", stb_cycles, exp_stb);
        check("s_ack pulses", sacks, abort ? 0 : 1);
        if (!abort) check("s_ack latency", sack_iter, timeout ? TO + 2 : lat + 3);
        check("m_adr", 32'(c_adr), 32'(exp_adr));
        check("m_sel", 32'(c_sel), adr[0] ? 32'hC : 32'h3);
        check("m_dat_w", c_dw, {wd, wd});
        check("m_we", 32'(c_we), 32'(we));
        check("m_cyc idle", 32'(m_cyc), 0);

        if (timeout) begin
            if (!we) mdl_rdata = ERRD;
            mdl_to = 1'b1;
            mdl_count_err();
        end else if (err_mode != 0) begin
            if (!we) mdl_rdata = ERRD;
            if (clr_err) begin
                mdl_errc = 8'h00; mdl_to = 1'b0;
            end else begin
                mdl_count_err();
            end
        end else if (!we) begin
            mdl_rdata = adr[0] ? rd[31:16] : rd[15:0];
        end
        check("s_dat_r model", 32'(s_dat_r), 32'(mdl_rdata));
        check("err_count model", 32'(err_count), 32'(mdl_errc));
        check("timeout_flag model", 32'(timeout_flag), 32'(mdl_to));
    endtask

    initial begin
        logic [29:0] c_adr;
        logic [3:0]  c_sel;
        logic [31:0] c_dw;
        logic        c_we;

        reset = 1'b1; s_adr = '0; s_dat_w = '0; s_we = 1'b0; s_cyc = 1'b0; s_stb = 1'b0;
        m_dat_r = '0; m_ack = 1'b0; m_err = 1'b0; clr_status = 1'b0;
        mdl_rdata = '0; mdl_errc = '0; mdl_to = 1'b0;

        vecs[0] = '{1'b1, 16'h0005, 16'hA55A, 32'h0, 3, 0, 0, 1'b0,
                    30'h1000_0002, 4'b1100, 32'hA55AA55A, 16'h0000, 8'd0, 1'b0};
        vecs[1] = '{1'b0, 16'h0004, 16'h0000, 32'h1234_5678, 0, 0, 0, 1'b0,
                    30'h1000_0002, 4'b0011, 32'h0, 16'h5678, 8'd0, 1'b0};
        vecs[2] = '{1'b0, 16'h0005, 16'h0000, 32'h1234_5678, 2, 0, 0, 1'b0,
                    30'h1000_0002, 4'b1100, 32'h0, 16'h1234, 8'd0, 1'b0};
        vecs[3] = '{1'b0, 16'h0006, 16'h0000, 32'h1234_5678, 1, 2, 0, 1'b0,
                    30'h1000_0003, 4'b0011, 32'h0, 16'hDEAD, 8'd1, 1'b0};
        vecs[4] = '{1'b0, 16'h0008, 16'h0000, 32'h1234_5678, 99, 0, 0, 1'b0,
                    30'h1000_0004, 4'b0011, 32'h0, 16'hDEAD, 8'd2, 1'b1};
        vecs[5] = '{1'b1, 16'h0000, 16'h1357, 32'h0, 0, 0, 10, 1'b0,
                    30'h1000_0000, 4'b0011, 32'h13571357, 16'hDEAD, 8'd2, 1'b1};
        vecs[6] = '{1'b1, 16'h0003, 16'h0F0F, 32'h0, 4, 0, 0, 1'b1,
                    30'h1000_0001, 4'b1100, 32'h0F0F0F0F, 16'hDEAD, 8'd2, 1'b1};
        vecs[7] = '{1'b1, 16'hFFFF, 16'h0001, 32'h0, 0, 0, 0, 1'b0,
                    30'h1000_7FFF, 4'b1100, 32'h00010001, 16'hDEAD, 8'd2, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        check("reset s_ack", 32'(s_ack), 0);
        check("reset m_cyc", 32'(m_cyc), 0);
        check("reset m_stb", 32'(m_stb), 0);
        check("reset m_adr", 32'(m_adr), 0);
        check("reset m_sel", 32'(m_sel), 0);
        check("reset s_dat_r", 32'(s_dat_r), 0);
        check("reset err_count", 32'(err_count), 0);
        check("reset timeout_flag", 32'(timeout_flag), 0);
        check("m_cti", 32'(m_cti), 0);
        check("m_bte", 32'(m_bte), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int v = 0; v < 8; v++) begin
            run_txn(vecs[v].we, vecs[v].adr, vecs[v].wd, vecs[v].rd, vecs[v].lat,
                    vecs[v].err_mode, vecs[v].hold, vecs[v].abort, 1'b0,
                    c_adr, c_sel, c_dw, c_we);
            check($sformatf("vec%0d m_adr", v), 32'(c_adr), 32'(vecs[v].e_adr));
            check($sformatf("vec%0d m_sel", v), 32'(c_sel), 32'(vecs[v].e_sel));
            check($sformatf("vec%0d m_dat_w", v), c_dw, vecs[v].e_dw);
            check($sformatf("vec%0d s_dat_r", v), 32'(s_dat_r), 32'(vecs[v].e_rdata));
            check($sformatf("vec%0d err_count", v), 32'(err_count), 32'(vecs[v].e_errc));
            check($sformatf("vec%0d timeout_flag", v), 32'(timeout_flag), 32'(vecs[v].e_to));
        end

        clr_status = 1'b1;
        @(posedge clk); #1;
        clr_status = 1'b0;
        mdl_errc = 8'h00; mdl_to = 1'b0;
        check("clr err_count", 32'(err_count), 0);
        check("clr timeout_flag", 32'(timeout_flag), 0);

        for (int r = 0; r < 40; r++) begin
            run_txn(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), $urandom,
                    int'($urandom_range(0, 20)), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0,
                    int'($urandom_range(0, 3)), 1'b0, 1'b0, c_adr, c_sel, c_dw, c_we);
        end

        run_txn(1'b0, 16'h0021, 16'h0, 32'hCAFE_F00D, 1, 1, 0, 1'b0, 1'b0, c_adr, c_sel, c_dw, c_we);
        run_txn(1'b0, 16'h0022, 16'h0, 32'hCAFE_F00D, 2, 1, 0, 1'b0, 1'b1, c_adr, c_sel, c_dw, c_we);
        check("clr priority err_count", 32'(err_count), 0);

        for (int k = 0; k < 300; k++) begin
            run_txn(1'b0, 16'(k), 16'h0, 32'h0, 0, 1, 0, 1'b0, 1'b0, c_adr, c_sel, c_dw, c_we);
        end
        check("err_count saturated", 32'(err_count), 32'hFF);

        s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b0; s_adr = 16'h0011; m_dat_r = 32'h0;
        repeat (5) @(posedge clk);
        #1;
        check("pre-reset m_stb", 32'(m_stb), 1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("midreq reset m_cyc", 32'(m_cyc), 0);
        check("midreq reset m_stb", 32'(m_stb), 0);
        check("midreq reset s_ack", 32'(s_ack), 0);
        check("midreq reset m_adr", 32'(m_adr), 0);
        check("midreq reset m_dat_w", m_dat_w, 0);
        check("midreq reset m_we", 32'(m_we), 0);
        check("midreq reset s_dat_r", 32'(s_dat_r), 0);
        check("midreq reset err_count", 32'(err_count), 0);
        check("midreq reset timeout_flag", 32'(timeout_flag), 0);
        s_cyc = 1'b0; s_stb = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        mdl_rdata = '0; mdl_errc = '0; mdl_to = 1'b0;
        @(posedge clk); #1;
        run_txn(1'b0, 16'h0101, 16'h0, 32'hBEEF_0123, 0, 0, 0, 1'b0, 1'b0, c_adr, c_sel, c_dw, c_we);
        check("post-reset read", 32'(s_dat_r), 32'h0000BEEF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
